hazard_stall_controller: RTL

//  Pipeline sequencer for the 5-stage ARM core. Watches the ID stage and the ID/EX load

---
 rtl/hazard_stall_controller_if.sv | 39 +++
 rtl/hazard_stall_controller.sv | 111 +++++++++++
 2 files changed

// File: rtl/hazard_stall_controller_if.sv
// Pipeline sequencer bundle: ID/EX hazard inputs, debug halt
// and the stall/flush controls plus statistics it produces.
interface hazard_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       id_rn;
    logic             id_rn_used;
    logic [3:0]       id_rm;
    logic             id_rm_used;
    logic [3:0]       id_rd;
    logic             id_rd_used;
    logic             id_branch_taken;
    logic             ex_mem_read;
    logic [3:0]       ex_rd;
    logic             halt_req;
    logic             pc_enable;
    logic             if_id_enable;
    logic             if_id_flush;
    logic             nop_select;
    logic             halt_ack;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rn, id_rn_used, id_rm, id_rm_used,
        output id_rd, id_rd_used, id_branch_taken,
        output ex_mem_read, ex_rd, halt_req,
        input  pc_enable, if_id_enable, if_id_flush,
        input  nop_select, halt_ack, stall_cycles, flush_count
    );

    modport slave (
        input  id_rn, id_rn_used, id_rm, id_rm_used,
        input  id_rd, id_rd_used, id_branch_taken,
        input  ex_mem_read, ex_rd, halt_req,
        output pc_enable, if_id_enable, if_id_flush,
        output nop_select, halt_ack, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use stall, branch squash and debug halt/drain sequencer
// for the 5-stage core, with saturating stall/flush statistics.
module hazard_stall_controller #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    hazard_stall_controller_if.slave    bus
);
    typedef enum logic [1:0] {RUN, BUBBLE, DRAIN, HALTED} state_t;

    localparam logic [1:0] BUB_INIT =
        (LOAD_USE_BUBBLES > 1) ? 2'(LOAD_USE_BUBBLES - 2) : 2'd0;
    localparam logic [CNT_W-1:0] SAT = '1;

    state_t           state, state_nxt;
    logic [1:0]       cnt, cnt_nxt;
    logic             ack, ack_nxt;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             stall, flush;
    logic             stall_inc, flush_inc;
    logic             load_use;

    assign load_use = bus.ex_mem_read &
        ((bus.id_rn_used & (bus.id_rn == bus.ex_rd)) |
         (bus.id_rm_used & (bus.id_rm == bus.ex_rd)) |
         (bus.id_rd_used & (bus.id_rd == bus.ex_rd)));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = ack;
        stall     = 1'b0;
        flush     = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.halt_req) begin
                    stall     = 1'b1;
                    state_nxt = DRAIN;
                    cnt_nxt   = 2'd2;
                end else if (load_use) begin
                    stall     = 1'b1;
                    stall_inc = 1'b1;
                    if (LOAD_USE_BUBBLES > 1) begin
                        state_nxt = BUBBLE;
                        cnt_nxt   = BUB_INIT;
                    end
                end else if (bus.id_branch_taken) begin
                    flush     = 1'b1;
                    flush_inc = 1'b1;
                end
            end
            BUBBLE: begin
                stall     = 1'b1;
                stall_inc = 1'b1;
                if (cnt == 2'd0) state_nxt = RUN;
                else             cnt_nxt   = cnt - 2'd1;
            end
            DRAIN: begin
                stall = 1'b1;
                if (cnt == 2'd0) begin
                    state_nxt = HALTED;
                    ack_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            HALTED: begin
                stall = 1'b1;
                if (!bus.halt_req) begin
                    state_nxt = RUN;
                    ack_nxt   = 1'b0;
                end
            end
        endcase
        // Pipeline must free-run while reset is held.
        if (reset) begin
            stall = 1'b0;
            flush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            cnt     <= 2'd0;
            ack     <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ack   <= ack_nxt;
            if (stall_inc && stall_q != SAT)
                stall_q <= stall_q + CNT_W'(1);
            if (flush_inc && flush_q != SAT)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.pc_enable    = ~stall;
    assign bus.if_id_enable = ~stall;
    assign bus.nop_select   = stall;
    assign bus.if_id_flush  = flush;
    assign bus.halt_ack     = ack;
    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
endmodule
